sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the team's fixed 8x16 FIFO. Adds simultaneous read/write in one cycle, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Used as the standard buffering stage between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param.sv | 112 +++++++++++
 tb/tb_sync_fifo_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO with simultaneous read/write, occupancy
//   count, programmable almost-full/almost-empty thresholds, sticky
//   overflow/underflow flags and a selectable first-word-fall-through mode.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   wr_en/wr_data write request and data
//   rd_en         read request (pop of the displayed word in FWFT mode)
//   clr_err       synchronous clear of overflow/underflow
//   rd_data       read data, qualified by rd_valid
//   full/empty    occupancy flags
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      occ;
    logic             wr_acc;
    logic             rd_acc;

    // Flags depend only on the registered pointers; the wrap bit
    // distinguishes full from empty when the index bits coincide.
    assign occ          = wr_ptr - rd_ptr;
    assign count        = occ;
    assign empty        = (occ == '0);
    assign full         = (occ == DEPTH_C);
    assign almost_full  = (occ >= AF_C);
    assign almost_empty = (occ <= AE_C);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown combinationally; forced to zero while empty so
            // that reset (which empties the FIFO) also drives rd_data to 0.
            assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
            assign rd_valid = !empty;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance and an FWFT instance
// share the same stimulus and are checked every cycle against a queue model,
// plus directed literal expectations.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en, rd_en, clr_err;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] d0_rd_data, d1_rd_data;
    logic             d0_rd_valid, d1_rd_valid;
    logic             d0_full, d1_full, d0_empty, d1_empty;
    logic             d0_af, d1_af, d0_ae, d1_ae;
    logic [4:0]       d0_count, d1_count;
    logic             d0_ovf, d1_ovf, d0_udf, d1_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .overflow(d0_ovf), .underflow(d0_udf)
    );

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .overflow(d1_ovf), .underflow(d1_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus the registered-read output.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf, m_udf, m_rv;
    logic [WIDTH-1:0] m_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
            m_rd  = '0;
        end else begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_empty = (q.size() == 0);
            m_ovf = (m_ovf && !clr_err) || (wr_en && was_full);
            m_udf = (m_udf && !clr_err) || (rd_en && was_empty);
            m_rv  = rd_en && !was_empty;
            if (m_rv) m_rd = q.pop_front();
            if (wr_en && !was_full) q.push_back(wr_data);
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        automatic int n = q.size();
        chk("d0_count", 32'(d0_count), n);
        chk("d0_empty", 32'(d0_empty), 32'(n == 0));
        chk("d0_full",  32'(d0_full),  32'(n == DEPTH));
        chk("d0_af",    32'(d0_af),    32'(n >= AFL));
        chk("d0_ae",    32'(d0_ae),    32'(n <= AEL));
        chk("d0_ovf",   32'(d0_ovf),   32'(m_ovf));
        chk("d0_udf",   32'(d0_udf),   32'(m_udf));
        chk("d0_rv",    32'(d0_rd_valid), 32'(m_rv));
        chk("d0_rd",    32'(d0_rd_data),  32'(m_rd));
        chk("d1_count", 32'(d1_count), n);
        chk("d1_empty", 32'(d1_empty), 32'(n == 0));
        chk("d1_full",  32'(d1_full),  32'(n == DEPTH));
        chk("d1_ovf",   32'(d1_ovf),   32'(m_ovf));
        chk("d1_udf",   32'(d1_udf),   32'(m_udf));
        chk("d1_rv",    32'(d1_rd_valid), 32'(n != 0));
        if (n != 0) chk("d1_rd", 32'(d1_rd_data), 32'(q[0]));
    end

    // Inputs are applied just after a falling edge; returns just after the
    // next falling edge, so outputs then reflect the rising edge in between.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk);
        @(negedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(d0_count), 0);
        chk({tag, "_empty"}, 32'(d0_empty), 1);
        chk({tag, "_ae"},    32'(d0_ae), 1);
        chk({tag, "_full"},  32'(d0_full), 0);
        chk({tag, "_af"},    32'(d0_af), 0);
        chk({tag, "_rv"},    32'(d0_rd_valid), 0);
        chk({tag, "_rd"},    32'(d0_rd_data), 0);
        chk({tag, "_ovf"},   32'(d0_ovf), 0);
        chk({tag, "_udf"},   32'(d0_udf), 0);
        chk({tag, "_f_rv"},  32'(d1_rd_valid), 0);
        chk({tag, "_f_rd"},  32'(d1_rd_data), 0);
        chk({tag, "_f_udf"}, 32'(d1_udf), 0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        #3;
        chk_reset_vals("rst0");
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b1;

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 13) chk("af_at13", 32'(d0_af), 0);
            if (i == 14) chk("af_at14", 32'(d0_af), 1);
        end
        chk("fill_full", 32'(d0_full), 1);
        chk("fill_count", 32'(d0_count), 16);

        // 17th write is dropped.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", 32'(d0_ovf), 1);
        chk("ovf_count", 32'(d0_count), 16);

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            chk("fwft_head", 32'(d1_rd_data), i);
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_rd", 32'(d0_rd_data), i);
            chk("drain_rv", 32'(d0_rd_valid), 1);
            if (i == 13) chk("ae_at3", 32'(d0_ae), 0);
            if (i == 14) chk("ae_at2", 32'(d0_ae), 1);
        end
        chk("drain_empty", 32'(d0_empty), 1);
        chk("drain_count", 32'(d0_count), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rv_drop", 32'(d0_rd_valid), 0);
        chk("rd_hold", 32'(d0_rd_data), 16);

        // Underflow and error clearing.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("udf_set", 32'(d0_udf), 1);
        chk("udf_rv", 32'(d0_rd_valid), 0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(d0_ovf), 0);
        chk("clr_udf", 32'(d0_udf), 0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("clr_vs_set", 32'(d0_udf), 1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Both requests at empty: write in, read refused.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("bemp_count", 32'(d0_count), 1);
        chk("bemp_udf", 32'(d0_udf), 1);
        chk("bemp_rv", 32'(d0_rd_valid), 0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Both requests at full: read out, write refused.
        for (int i = 0; i < 15; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
        chk("bful_pre", 32'(d0_count), 16);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("bful_count", 32'(d0_count), 15);
        chk("bful_ovf", 32'(d0_ovf), 1);
        chk("bful_rd", 32'(d0_rd_data), 8'h77);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("bful_last", 32'(d0_rd_data), 8'h3E);

        // Sustained simultaneous traffic at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h20 + i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, WIDTH'(8'h25 + k), 1'b1, 1'b0);
            chk("sim_count", 32'(d0_count), 5);
            chk("sim_rd", 32'(d0_rd_data), 32'(8'h20 + k));
        end
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("sim_tail", 32'(d0_rd_data), 8'h4C);

        // FWFT: word visible the cycle after it is written.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_rd", 32'(d1_rd_data), 8'hA5);
        chk("fwft_rv", 32'(d1_rd_valid), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_empty", 32'(d1_empty), 1);
        chk("fwft_rv0", 32'(d1_rd_valid), 0);

        // Asynchronous reset mid-operation.
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(d0_count), 9);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk); #1;
        rst = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_f_rd", 32'(d1_rd_data), 8'h3C);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_rd", 32'(d0_rd_data), 8'h3C);
        chk("post_rst_count", 32'(d0_count), 0);

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
